// File: rtl/dualport_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dualport_ram_ctrl
// Simple dual-port RAM: byte-enabled writes, 1/2-cycle registered reads,
// selectable read-during-write result and a post-reset zero-fill sequencer.
// Rev    : 1.0
// ============================================================================
module dualport_ram_ctrl #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 10,
    parameter int READ_LATENCY  = 1,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        length,
    input  logic [DEPTH-1:0]   raddress,
    input  logic [DEPTH-1:0]   waddress,
    input  logic [WIDTH-1:0]   din,
    input  logic [WIDTH/8-1:0] be,
    input  logic               we,
    input  logic               oe,
    output logic [WIDTH-1:0]   dout,
    output logic               rvalid,
    output logic               init_busy
);
    localparam int NB    = WIDTH / 8;
    localparam int WORDS = 2 ** DEPTH;

    generate
        if (WIDTH % 8 != 0) begin : g_bad_width
            $error("dualport_ram_ctrl: WIDTH must be a multiple of 8");
        end
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("dualport_ram_ctrl: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [DEPTH-1:0] cnt_q;
    logic             init_busy_q;
    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_valid_q;
    logic [WIDTH-1:0] dout_q;
    logic             rvalid_q;
    logic             rd_accept;

    assign length    = 32'(WORDS);
    assign init_busy = init_busy_q;
    assign dout      = dout_q;
    assign rvalid    = rvalid_q;
    assign rd_accept = (state_q == ST_RUN) && oe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            if (INIT_ON_RESET != 0) begin
                state_q     <= ST_INIT;
                init_busy_q <= 1'b1;
            end else begin
                state_q     <= ST_RUN;
                init_busy_q <= 1'b0;
            end
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + DEPTH'(1);
            if (&cnt_q) begin
                state_q     <= ST_RUN;
                init_busy_q <= 1'b0;
            end
        end
    end

    // The sequencer owns the write port while zero-filling; user writes are dropped.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem_q[waddress][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    generate
        if (RDW_MODE != 0) begin : g_rdw_new
            logic same_addr;
            assign same_addr = (state_q == ST_RUN) && we && (raddress == waddress);
            for (genvar i = 0; i < NB; i++) begin : g_lane
                assign rd_data_d[8*i +: 8] = (same_addr && be[i]) ? din[8*i +: 8]
                                                                   : mem_q[raddress][8*i +: 8];
            end
        end else begin : g_rdw_old
            assign rd_data_d = mem_q[raddress];
        end
    endgenerate

    // Memory read register: captures the addressed word on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_accept;
            if (rd_accept) begin
                s1_data_q <= rd_data_d;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [WIDTH-1:0] s2_data_q;
            logic             s2_valid_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                    rvalid_q   <= 1'b0;
                    dout_q     <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                    rvalid_q <= s2_valid_q;
                    if (s2_valid_q) begin
                        dout_q <= s2_data_q;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rvalid_q <= 1'b0;
                    dout_q   <= '0;
                end else begin
                    rvalid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        dout_q <= s1_data_q;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dualport_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dualport_ram_ctrl
// Three configurations of dualport_ram_ctrl driven by one directed vector table.
// Rev    : 1.0
// ============================================================================
module tb_dualport_ram_ctrl;
    localparam int W = 32;
    localparam int D = 4;

    typedef struct {
        logic          we;
        logic [3:0]    be;
        logic [D-1:0]  wa;
        logic [W-1:0]  din;
        logic          oe;
        logic [D-1:0]  ra;
        logic [W-1:0]  e0;   // u0: latency 1, old-data collisions
        logic [W-1:0]  e1;   // u1: latency 2, new-data collisions
        logic [W-1:0]  e2;   // u2: latency 1, new-data collisions, no zero-fill
        logic          c2;   // u2 data is defined for this read
    } vec_t;

    typedef struct {
        int         due;
        logic [W-1:0] d;
        logic       chk;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [D-1:0]  raddress;
    logic [D-1:0]  waddress;
    logic [W-1:0]  din;
    logic [3:0]    be;
    logic          we;
    logic          oe;
    logic [31:0]   length_a [3];
    logic [W-1:0]  dout_a   [3];
    logic          rvalid_a [3];
    logic          busy_a   [3];

    int   checks;
    int   failures;
    int   cyc;
    logic mon_en;
    logic mon_exp;
    exp_t q [3][$];
    vec_t tbl [$];

    dualport_ram_ctrl #(.WIDTH(W), .DEPTH(D), .READ_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)) u0 (
        .clk(clk), .reset(reset), .length(length_a[0]), .raddress(raddress), .waddress(waddress),
        .din(din), .be(be), .we(we), .oe(oe), .dout(dout_a[0]), .rvalid(rvalid_a[0]),
        .init_busy(busy_a[0])
    );
    dualport_ram_ctrl #(.WIDTH(W), .DEPTH(D), .READ_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(1)) u1 (
        .clk(clk), .reset(reset), .length(length_a[1]), .raddress(raddress), .waddress(waddress),
        .din(din), .be(be), .we(we), .oe(oe), .dout(dout_a[1]), .rvalid(rvalid_a[1]),
        .init_busy(busy_a[1])
    );
    dualport_ram_ctrl #(.WIDTH(W), .DEPTH(D), .READ_LATENCY(1), .RDW_MODE(1), .INIT_ON_RESET(0)) u2 (
        .clk(clk), .reset(reset), .length(length_a[2]), .raddress(raddress), .waddress(waddress),
        .din(din), .be(be), .we(we), .oe(oe), .dout(dout_a[2]), .rvalid(rvalid_a[2]),
        .init_busy(busy_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic we_v, input logic [3:0] be_v, input logic [D-1:0] wa_v,
                                input logic [W-1:0] din_v, input logic oe_v, input logic [D-1:0] ra_v,
                                input logic [W-1:0] e0_v, input logic [W-1:0] e1_v,
                                input logic [W-1:0] e2_v, input logic c2_v);
        vec_t v;
        v.we = we_v; v.be = be_v; v.wa = wa_v; v.din = din_v; v.oe = oe_v; v.ra = ra_v;
        v.e0 = e0_v; v.e1 = e1_v; v.e2 = e2_v; v.c2 = c2_v;
        return v;
    endfunction

    function automatic vec_t wr(input logic [D-1:0] a, input logic [W-1:0] d, input logic [3:0] b);
        return mk(1'b1, b, a, d, 1'b0, '0, '0, '0, '0, 1'b0);
    endfunction

    function automatic vec_t rd(input logic [D-1:0] a, input logic [W-1:0] e0_v,
                                input logic [W-1:0] e1_v, input logic [W-1:0] e2_v, input logic c2_v);
        return mk(1'b0, 4'h0, '0, '0, 1'b1, a, e0_v, e1_v, e2_v, c2_v);
    endfunction

    function automatic exp_t mk_exp(input int due, input logic [W-1:0] d, input logic chk);
        exp_t e;
        e.due = due; e.d = d; e.chk = chk;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", nm, got, want);
        end
    endtask

    // Outputs change only on posedge, so negedge sampling sees settled values.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                mon_exp = (q[i].size() > 0) && (q[i][0].due == cyc);
                checks++;
                if (rvalid_a[i] !== mon_exp) begin
                    failures++;
                    $display("FAIL rvalid u%0d cyc=%0d: got=%b want=%b", i, cyc, rvalid_a[i], mon_exp);
                end
                if (mon_exp) begin
                    if (q[i][0].chk) begin
                        checks++;
                        if (dout_a[i] !== q[i][0].d) begin
                            failures++;
                            $display("FAIL dout u%0d cyc=%0d: got=%h want=%h", i, cyc, dout_a[i], q[i][0].d);
                        end
                    end
                    void'(q[i].pop_front());
                end
            end
        end
    end

    task automatic apply(input vec_t v);
        we = v.we; be = v.be; waddress = v.wa; din = v.din; oe = v.oe; raddress = v.ra;
        if (v.oe) begin
            q[0].push_back(mk_exp(cyc + 2, v.e0, 1'b1));
            q[1].push_back(mk_exp(cyc + 3, v.e1, 1'b1));
            q[2].push_back(mk_exp(cyc + 2, v.e2, v.c2));
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        we = 1'b0; oe = 1'b0; be = 4'h0;
        repeat (n) @(negedge clk);
    endtask

    // Called on the negedge where reset drops; counts init_busy and issues oe throughout.
    task automatic init_window(input logic first);
        int   n0, n1;
        logic u2_busy;
        n0 = 0; n1 = 0; u2_busy = 1'b0;
        for (int k = 0; k < 21; k++) begin
            if (busy_a[0] === 1'b1) n0++;
            if (busy_a[1] === 1'b1) n1++;
            if (busy_a[2] !== 1'b0) u2_busy = 1'b1;
            if (k < 16) begin
                apply(mk(first && (k == 0), 4'hF, 4'd9, 32'hCAFE_F00D, 1'b1, 4'd9,
                         '0, '0, 32'hCAFE_F00D, 1'b1));
                q[0].delete();
                q[1].delete();
            end else begin
                idle(1);
            end
        end
        chk("u0 init_busy cycles", 32'(n0), 32'd16);
        chk("u1 init_busy cycles", 32'(n1), 32'd16);
        chk("u2 init_busy never set", {31'd0, u2_busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0; mon_en = 1'b0; mon_exp = 1'b0;
        reset = 1'b1; we = 1'b0; oe = 1'b0; be = 4'h0; din = '0; waddress = '0; raddress = '0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d length", i), length_a[i], 32'd16);
            chk($sformatf("u%0d reset rvalid", i), {31'd0, rvalid_a[i]}, 32'd0);
            chk($sformatf("u%0d reset dout", i), dout_a[i], 32'd0);
        end
        chk("u0 reset init_busy", {31'd0, busy_a[0]}, 32'd1);
        chk("u1 reset init_busy", {31'd0, busy_a[1]}, 32'd1);
        chk("u2 reset init_busy", {31'd0, busy_a[2]}, 32'd0);

        reset = 1'b0;
        mon_en = 1'b1;
        init_window(1'b1);

        for (int a = 0; a < 16; a++) tbl.push_back(rd(D'(a), '0, '0, '0, 1'b0));
        tbl.push_back(wr(4'd3, 32'hAABB_CCDD, 4'hF));
        tbl.push_back(wr(4'd3, 32'h1122_3344, 4'b0101));
        tbl.push_back(rd(4'd3, 32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44, 1'b1));
        for (int a = 0; a < 4; a++) tbl.push_back(wr(D'(a), 32'h10 + 32'(a), 4'hF));
        for (int a = 0; a < 4; a++) tbl.push_back(rd(D'(a), 32'h10 + 32'(a), 32'h10 + 32'(a), 32'h10 + 32'(a), 1'b1));
        tbl.push_back(wr(4'd5, 32'h1234_5678, 4'hF));
        tbl.push_back(mk(1'b1, 4'b0011, 4'd5, 32'hFFFF_FFFF, 1'b1, 4'd5,
                         32'h1234_5678, 32'h1234_FFFF, 32'h1234_FFFF, 1'b1));
        tbl.push_back(rd(4'd5, 32'h1234_FFFF, 32'h1234_FFFF, 32'h1234_FFFF, 1'b1));
        tbl.push_back(wr(4'd6, 32'h5555_AAAA, 4'hF));
        tbl.push_back(mk(1'b1, 4'hF, 4'd6, 32'h0, 1'b1, 4'd5,
                         32'h1234_FFFF, 32'h1234_FFFF, 32'h1234_FFFF, 1'b1));
        tbl.push_back(rd(4'd6, 32'h0, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'd0, '0, '0, '0, 1'b0));
        tbl.push_back(rd(4'd5, 32'h1234_FFFF, 32'h1234_FFFF, 32'h1234_FFFF, 1'b1));
        tbl.push_back(wr(4'd7, 32'hDEAD_BEEF, 4'hF));
        tbl.push_back(mk(1'b1, 4'b1100, 4'd7, 32'h0, 1'b1, 4'd7,
                         32'hDEAD_BEEF, 32'h0000_BEEF, 32'h0000_BEEF, 1'b1));
        tbl.push_back(rd(4'd7, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0000_BEEF, 1'b1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        idle(4);
        for (int i = 0; i < 3; i++) chk($sformatf("u%0d reads drained", i), 32'(q[i].size()), 32'd0);

        // Two reads in flight in the latency-2 instance when reset hits.
        mon_en = 1'b0;
        we = 1'b0; oe = 1'b1; raddress = 4'd3;
        @(negedge clk);
        raddress = 4'd5;
        @(negedge clk);
        oe = 1'b0;
        chk("u0 rvalid before reset", {31'd0, rvalid_a[0]}, 32'd1);
        chk("u0 dout before reset", dout_a[0], 32'h13);
        chk("u1 rvalid before reset", {31'd0, rvalid_a[1]}, 32'd0);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d async reset rvalid", i), {31'd0, rvalid_a[i]}, 32'd0);
            chk($sformatf("u%0d async reset dout", i), dout_a[i], 32'd0);
        end
        repeat (2) @(negedge clk);
        chk("u1 rvalid held in reset", {31'd0, rvalid_a[1]}, 32'd0);
        for (int i = 0; i < 3; i++) q[i].delete();
        reset = 1'b0;
        mon_en = 1'b1;
        init_window(1'b0);

        tbl.delete();
        tbl.push_back(rd(4'd0, 32'h0, 32'h0, 32'h10, 1'b1));
        tbl.push_back(rd(4'd3, 32'h0, 32'h0, 32'h13, 1'b1));
        tbl.push_back(rd(4'd5, 32'h0, 32'h0, 32'h1234_FFFF, 1'b1));
        tbl.push_back(rd(4'd15, 32'h0, 32'h0, 32'h0, 1'b0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        idle(4);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d final reads drained", i), 32'(q[i].size()), 32'd0);
            chk($sformatf("u%0d final length", i), length_a[i], 32'd16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
